// File: rtl/mmio_timer_bank.sv
// Memory-mapped bank of NUM_CH timers. Each channel has a prescaled up-counter with limit compare,
// one-shot or periodic reload, sticky RDY/OVR status and a maskable contribution to one level interrupt.
module mmio_timer_bank #(
  parameter int unsigned DBITS      = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0020,
  parameter int unsigned PRESC_BITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DBITS-1:0] abus,
  inout  wire  [DBITS-1:0] dbus,
  input  logic             we,
  output logic             intr
);

  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SPAN          = 16 * NUM_CH;
  localparam int unsigned CTL_EN        = 0;
  localparam int unsigned CTL_PER       = 1;
  localparam int unsigned CTL_IE        = 2;
  localparam int unsigned CTL_PRESC_LSB = 8;
  localparam int unsigned STAT_RDY      = 0;
  localparam int unsigned STAT_OVR      = 1;
  localparam logic [DBITS-1:0] BASE     = DBITS'(BASE_ADDR);
  localparam logic [DBITS-1:0] SPAN_W   = DBITS'(SPAN);

  typedef enum logic [1:0] {
    REG_CNT  = 2'd0,
    REG_LIM  = 2'd1,
    REG_CTL  = 2'd2,
    REG_STAT = 2'd3
  } reg_e;

  // Per-channel architectural state
  logic [DBITS-1:0]      cnt_q   [NUM_CH];
  logic [DBITS-1:0]      cnt_d   [NUM_CH];
  logic [DBITS-1:0]      lim_q   [NUM_CH];
  logic [DBITS-1:0]      lim_d   [NUM_CH];
  logic [PRESC_BITS-1:0] presc_q [NUM_CH];
  logic [PRESC_BITS-1:0] presc_d [NUM_CH];
  logic [PRESC_BITS-1:0] pre_q   [NUM_CH];
  logic [PRESC_BITS-1:0] pre_d   [NUM_CH];
  logic [NUM_CH-1:0]     en_q, en_d;
  logic [NUM_CH-1:0]     per_q, per_d;
  logic [NUM_CH-1:0]     ie_q, ie_d;
  logic [NUM_CH-1:0]     rdy_q, rdy_d;
  logic [NUM_CH-1:0]     ovr_q, ovr_d;

  logic [DBITS-1:0]  off_c;
  logic              hit_c;
  logic [CH_W-1:0]   sel_ch_c;
  reg_e              sel_reg_c;
  logic [DBITS-1:0]  wdata_c;
  logic [DBITS-1:0]  rd_data_c;
  logic [NUM_CH-1:0] tick_c;
  logic [NUM_CH-1:0] expire_c;
  logic [NUM_CH-1:0] wr_sel_c;

  // Address decode; abus[1:0] never reaches the register select
  always_comb begin
    off_c     = abus - BASE;
    hit_c     = (abus >= BASE) && (off_c < SPAN_W);
    sel_ch_c  = off_c[CH_W+3:4];
    sel_reg_c = reg_e'(off_c[3:2]);
  end

  assign wdata_c = dbus;

  // Prescaler tick, limit expiry and write select per channel
  always_comb begin
    tick_c   = '0;
    expire_c = '0;
    wr_sel_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tick_c[c]   = en_q[c] && (pre_q[c] == presc_q[c]);
      expire_c[c] = tick_c[c] && (cnt_q[c] >= lim_q[c]);
      wr_sel_c[c] = we && hit_c && (sel_ch_c == CH_W'(c));
    end
  end

  // Next-state: counting first, then bus writes override, then hardware status sets win over W1C
  always_comb begin
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    presc_d = presc_q;
    pre_d   = pre_q;
    en_d    = en_q;
    per_d   = per_q;
    ie_d    = ie_q;
    rdy_d   = rdy_q;
    ovr_d   = ovr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (en_q[c]) begin
        pre_d[c] = tick_c[c] ? '0 : pre_q[c] + PRESC_BITS'(1);
      end
      if (tick_c[c]) begin
        cnt_d[c] = expire_c[c] ? '0 : cnt_q[c] + DBITS'(1);
      end
      if (expire_c[c] && !per_q[c]) begin
        en_d[c] = 1'b0;
      end
      if (wr_sel_c[c]) begin
        case (sel_reg_c)
          REG_CNT: begin
            cnt_d[c] = wdata_c;
            pre_d[c] = '0;
          end
          REG_LIM: lim_d[c] = wdata_c;
          REG_CTL: begin
            en_d[c]    = wdata_c[CTL_EN];
            per_d[c]   = wdata_c[CTL_PER];
            ie_d[c]    = wdata_c[CTL_IE];
            presc_d[c] = wdata_c[CTL_PRESC_LSB+PRESC_BITS-1:CTL_PRESC_LSB];
          end
          REG_STAT: begin
            rdy_d[c] = rdy_q[c] & ~wdata_c[STAT_RDY];
            ovr_d[c] = ovr_q[c] & ~wdata_c[STAT_OVR];
          end
          default: ;
        endcase
      end
      if (expire_c[c]) begin
        rdy_d[c] = 1'b1;
        if (rdy_q[c]) begin
          ovr_d[c] = 1'b1;
        end
      end
    end
  end

  // Zero-latency read mux
  always_comb begin
    rd_data_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch_c == CH_W'(c)) begin
        case (sel_reg_c)
          REG_CNT: rd_data_c = cnt_q[c];
          REG_LIM: rd_data_c = lim_q[c];
          REG_CTL: begin
            rd_data_c[CTL_EN]  = en_q[c];
            rd_data_c[CTL_PER] = per_q[c];
            rd_data_c[CTL_IE]  = ie_q[c];
            rd_data_c[CTL_PRESC_LSB+PRESC_BITS-1:CTL_PRESC_LSB] = presc_q[c];
          end
          REG_STAT: begin
            rd_data_c[STAT_RDY] = rdy_q[c];
            rd_data_c[STAT_OVR] = ovr_q[c];
          end
          default: ;
        endcase
      end
    end
  end

  assign dbus = (hit_c && !we) ? rd_data_c : {DBITS{1'bz}};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]   <= '0;
        lim_q[c]   <= '0;
        presc_q[c] <= '0;
        pre_q[c]   <= '0;
      end
      en_q  <= '0;
      per_q <= '0;
      ie_q  <= '0;
      rdy_q <= '0;
      ovr_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      presc_q <= presc_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
      per_q   <= per_d;
      ie_q    <= ie_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign intr = |(rdy_q & ie_q);

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Bench for mmio_timer_bank: directed scenarios with fixed expectations, then random bus
// traffic compared against a register-level reference model stepped once per clock.
module tb_mmio_timer_bank;

  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'hF000_0020;
  localparam logic [31:0] TOP  = BASE + 32'(16 * NCH);
  localparam logic [31:0] KEEP = 32'h5AC3_3CA5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic        drv;
  logic [31:0] abus;
  logic [31:0] dout;
  wire  [31:0] dbus;
  logic        intr;

  assign dbus = drv ? dout : 32'bz;
  always #5 clk = ~clk;

  mmio_timer_bank #(
    .DBITS(32), .NUM_CH(NCH), .BASE_ADDR(BASE), .PRESC_BITS(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .abus(abus), .dbus(dbus), .we(we), .intr(intr)
  );

  int n_chk;
  int n_bad;

  // Reference model state
  logic [31:0] m_cnt   [NCH];
  logic [31:0] m_lim   [NCH];
  logic [7:0]  m_presc [NCH];
  logic [7:0]  m_pre   [NCH];
  logic        m_en    [NCH];
  logic        m_per   [NCH];
  logic        m_ie    [NCH];
  logic        m_rdy   [NCH];
  logic        m_ovr   [NCH];

  function automatic logic [31:0] ra(input int c, input int r);
    return BASE + 32'(16 * c) + 32'(4 * r);
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < TOP);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned ch;
    int unsigned r;
    logic [31:0] v;
    ch = (a - BASE) / 16;
    r  = ((a - BASE) % 16) / 4;
    v  = 32'h0;
    case (r)
      0: v = m_cnt[ch];
      1: v = m_lim[ch];
      2: v = {16'h0, m_presc[ch], 5'h0, m_ie[ch], m_per[ch], m_en[ch]};
      default: v = {30'h0, m_ovr[ch], m_rdy[ch]};
    endcase
    return v;
  endfunction

  function automatic logic m_intr();
    logic v;
    v = 1'b0;
    for (int c = 0; c < NCH; c++) v = v | (m_rdy[c] & m_ie[c]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Applies one clock edge worth of the register rules to the model, using the inputs now on the bus
  task automatic model_step();
    logic        whit;
    int unsigned wch;
    int unsigned wreg;
    logic        tick;
    logic        fire;
    logic [31:0] n_cnt;
    logic [7:0]  n_pre;
    logic        n_en;
    logic        n_rdy;
    logic        n_ovr;
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_lim[c] = 0; m_presc[c] = 0; m_pre[c] = 0;
        m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_rdy[c] = 0; m_ovr[c] = 0;
      end
      return;
    end
    whit = we && in_rng(abus);
    wch  = (abus - BASE) / 16;
    wreg = ((abus - BASE) % 16) / 4;
    for (int c = 0; c < NCH; c++) begin
      tick = 0; fire = 0;
      n_cnt = m_cnt[c]; n_pre = m_pre[c]; n_en = m_en[c]; n_rdy = m_rdy[c]; n_ovr = m_ovr[c];
      if (m_en[c]) begin
        if (m_pre[c] == m_presc[c]) begin
          n_pre = 0;
          tick  = 1;
        end else begin
          n_pre = m_pre[c] + 8'd1;
        end
      end
      if (tick) begin
        if (m_cnt[c] >= m_lim[c]) begin
          fire  = 1;
          n_cnt = 0;
          if (!m_per[c]) n_en = 0;
        end else begin
          n_cnt = m_cnt[c] + 32'd1;
        end
      end
      if (whit && wch == 32'(c)) begin
        case (wreg)
          0: begin n_cnt = dout; n_pre = 0; end
          1: m_lim[c] = dout;
          2: begin
            n_en = dout[0]; m_per[c] = dout[1]; m_ie[c] = dout[2]; m_presc[c] = dout[15:8];
          end
          default: begin
            if (dout[0]) n_rdy = 0;
            if (dout[1]) n_ovr = 0;
          end
        endcase
      end
      if (fire) begin
        n_ovr = n_ovr | m_rdy[c];
        n_rdy = 1;
      end
      m_cnt[c] = n_cnt; m_pre[c] = n_pre; m_en[c] = n_en; m_rdy[c] = n_rdy; m_ovr[c] = n_ovr;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    abus = a; dout = d; drv = 1'b1; we = 1'b1;
    step();
    we = 1'b0; drv = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    abus = a; drv = 1'b0; we = 1'b0;
    #1;
    chk(tag, dbus, exp);
  endtask

  // Out-of-range reads: the bench holds a keeper pattern, which must come back undisturbed
  task automatic rd_mdl(input string tag, input logic [31:0] a);
    if (in_rng(a)) begin
      rd_chk(tag, a, m_read(a));
    end else begin
      abus = a; we = 1'b0; dout = KEEP; drv = 1'b1;
      #1;
      chk(tag, dbus, KEEP);
      drv = 1'b0;
    end
  endtask

  task automatic intr_chk(input string tag, input logic exp);
    chk(tag, {31'h0, intr}, {31'h0, exp});
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned k;
    k = $urandom_range(0, 15);
    if (k == 0) return TOP + 32'($urandom_range(0, 15));
    if (k == 1) return BASE - 32'($urandom_range(1, 8));
    if (k == 2) return $urandom;
    return ra(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 3))) + 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] pick_data(input logic [31:0] a);
    logic [31:0] d;
    if (!in_rng(a)) return $urandom;
    case (((a - BASE) % 16) / 4)
      0: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2))
                                          : 32'($urandom_range(0, 12));
      1: d = 32'($urandom_range(0, 6));
      2: begin
        d       = $urandom;
        d[15:8] = 8'($urandom_range(0, 3));
        d[0]    = ($urandom_range(0, 3) != 0);
      end
      default: d = 32'($urandom_range(0, 3));
    endcase
    return d;
  endfunction

  initial begin
    n_chk = 0; n_bad = 0;
    reset_n = 1'b0; we = 1'b0; drv = 1'b0; abus = 32'h0; dout = 32'h0;
    step(); step();
    reset_n = 1'b1;

    // Reset during an active count
    wr(ra(0, 1), 32'd3);
    wr(ra(0, 2), 32'h7);
    step(); step(); step();
    rd_chk("pre_rst_cnt", ra(0, 0), 32'd3);
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    intr_chk("rst_intr", 1'b0);
    for (int c = 0; c < NCH; c++) begin
      for (int r = 0; r < 4; r++) rd_chk("rst_reg", ra(c, r), 32'h0);
      step();
    end
    rd_mdl("rst_oor_top", TOP);
    rd_mdl("rst_oor_low", BASE - 32'd4);

    // Periodic ch0, LIM=3, PRESC=0
    wr(ra(0, 1), 32'd3);
    wr(ra(0, 2), 32'h7);
    rd_chk("per_cnt0", ra(0, 0), 32'd0);
    step(); rd_chk("per_cnt1", ra(0, 0), 32'd1);
    step(); rd_chk("per_cnt2", ra(0, 0), 32'd2);
    step(); rd_chk("per_cnt3", ra(0, 0), 32'd3);
    rd_chk("per_stat_pre", ra(0, 3), 32'h0);
    intr_chk("per_intr_pre", 1'b0);
    step(); rd_chk("per_cnt_wrap", ra(0, 0), 32'd0);
    rd_chk("per_stat_rdy", ra(0, 3), 32'h1);
    intr_chk("per_intr", 1'b1);
    step(); step(); step();
    rd_chk("per_stat_mid", ra(0, 3), 32'h1);
    step();
    rd_chk("ovr_stat", ra(0, 3), 32'h3);
    intr_chk("ovr_intr", 1'b1);
    wr(ra(0, 3), 32'h1);
    rd_chk("w1c_rdy", ra(0, 3), 32'h2);
    intr_chk("w1c_intr", 1'b0);
    wr(ra(0, 3), 32'h2);
    rd_chk("w1c_ovr", ra(0, 3), 32'h0);
    intr_chk("w1c_intr2", 1'b0);
    wr(ra(0, 2), 32'h0);
    step(); step();
    rd_chk("frz_cnt", ra(0, 0), 32'd3);
    rd_chk("frz_stat", ra(0, 3), 32'h0);

    // One-shot ch2, LIM=1, PRESC=2: expiry 6 cycles after enable
    wr(ra(2, 1), 32'd1);
    wr(ra(2, 2), 32'h0205);
    step(); step(); step();
    rd_chk("os_cnt_mid", ra(2, 0), 32'd1);
    step(); step();
    rd_chk("os_stat_pre", ra(2, 3), 32'h0);
    step();
    rd_chk("os_stat", ra(2, 3), 32'h1);
    rd_chk("os_ctl", ra(2, 2), 32'h0204);
    intr_chk("os_intr", 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      rd_chk("os_hold_cnt", ra(2, 0), 32'd0);
      rd_chk("os_hold_ctl", ra(2, 2), 32'h0204);
    end
    wr(ra(2, 3), 32'h1);
    intr_chk("os_clr_intr", 1'b0);

    // W1C on the same cycle as a new expiry
    wr(ra(1, 1), 32'd1);
    wr(ra(1, 2), 32'h3);
    step(); step();
    rd_chk("col_stat1", ra(1, 3), 32'h1);
    step();
    wr(ra(1, 3), 32'h1);
    rd_chk("col_w1c_lose", ra(1, 3), 32'h3);
    wr(ra(1, 2), 32'h0);
    wr(ra(1, 3), 32'h3);

    // CNT writes restart the prescaler (PRESC=1)
    wr(ra(0, 1), 32'd10);
    wr(ra(0, 0), 32'd0);
    wr(ra(0, 2), 32'h0101);
    step(); step(); step();
    wr(ra(0, 0), 32'd0);
    rd_chk("cw_tick", ra(0, 0), 32'd0);
    step(); rd_chk("cw_a", ra(0, 0), 32'd0);
    step(); rd_chk("cw_b", ra(0, 0), 32'd1);
    wr(ra(0, 0), 32'd5);
    rd_chk("cw_c", ra(0, 0), 32'd5);
    step(); rd_chk("cw_pre_clr", ra(0, 0), 32'd5);
    step(); rd_chk("cw_d", ra(0, 0), 32'd6);
    wr(ra(0, 2), 32'h0);

    // Interrupt mask across channels
    wr(ra(1, 1), 32'd0);
    wr(ra(1, 2), 32'h1);
    step();
    rd_chk("mask_stat1", ra(1, 3), 32'h1);
    intr_chk("mask_intr_off", 1'b0);
    wr(ra(3, 1), 32'd0);
    wr(ra(3, 2), 32'h5);
    step();
    intr_chk("mask_intr_ch3", 1'b1);
    wr(ra(3, 3), 32'h1);
    intr_chk("mask_intr_clr", 1'b0);
    rd_chk("mask_stat1_keep", ra(1, 3), 32'h1);
    wr(ra(1, 2), 32'h4);
    intr_chk("mask_intr_ch1", 1'b1);
    wr(ra(1, 3), 32'h1);
    intr_chk("mask_intr_end", 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = pick_addr();
      rd_mdl("rnd_rd", a);
      intr_chk("rnd_intr", m_intr());
      if (i == 1500) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end else if ($urandom_range(0, 9) < 4) begin
        a = pick_addr();
        wr(a, pick_data(a));
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
